// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if: producer-side and consumer-side handshakes of rr_arb_mux.
// RR_ARB_MUX_LOCK_EN adds in_last for packet locking.
interface rr_arb_mux_if #(
  parameter int WIDTH = 64,
  parameter int N     = 4
);
  localparam int SELW = $clog2(N);

  logic                      mode;       // 0 fixed priority, 1 round-robin
  logic [N-1:0]              in_valid;
  logic [N-1:0][WIDTH-1:0]   in_data;    // channel i at [i*WIDTH +: WIDTH]
  logic [N-1:0]              in_ready;
`ifdef RR_ARB_MUX_LOCK_EN
  logic [N-1:0]              in_last;
`endif
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;
  logic [SELW-1:0]           out_sel;
  logic                      out_ready;

  // Producers/consumer (bench side).
  modport master (
    output mode, in_valid, in_data, out_ready,
`ifdef RR_ARB_MUX_LOCK_EN
    output in_last,
`endif
    input  in_ready, out_valid, out_data, out_sel
  );

  // Arbiter side.
  modport slave (
    input  mode, in_valid, in_data, out_ready,
`ifdef RR_ARB_MUX_LOCK_EN
    input  in_last,
`endif
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: registered N-to-1 data mux, fixed-priority or round-robin grant,
// one output register stage (1 beat/cycle, 1 cycle latency).
// Optional macro RR_ARB_MUX_LOCK_EN: a granted channel keeps the port until a
// beat with in_last=1 is loaded.
module rr_arb_mux #(
  parameter  int WIDTH = 64,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input logic         clk,
  input logic         reset,
  rr_arb_mux_if.slave bus
);

  logic             gnt_any;
  logic [SELW-1:0]  gnt_idx;
  logic             can_load;
  logic             load;
  int               rr_j;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_sel_q,   out_sel_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

`ifdef RR_ARB_MUX_LOCK_EN
  typedef enum logic {IDLE, LOCKED} lk_state_e;
  lk_state_e        state_q, state_d;
  logic [SELW-1:0]  lock_ch_q, lock_ch_d;
`endif

  // Grant select: scan from highest candidate down so the first in search
  // order is the last one written; rr search wraps without a modulo.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_j    = 0;
    if (!bus.mode) begin
      for (int i = N-1; i >= 0; i--) begin
        if (bus.in_valid[i]) begin
          gnt_any = 1'b1;
          gnt_idx = SELW'(i);
        end
      end
    end else begin
      for (int k = N-1; k >= 0; k--) begin
        rr_j = int'(ptr_q) + k;
        if (rr_j >= N) rr_j = rr_j - N;
        if (bus.in_valid[rr_j]) begin
          gnt_any = 1'b1;
          gnt_idx = SELW'(rr_j);
        end
      end
    end
`ifdef RR_ARB_MUX_LOCK_EN
    // A locked channel owns the port; if it idles, nobody else gets in.
    if (state_q == LOCKED) begin
      gnt_any = bus.in_valid[lock_ch_q];
      gnt_idx = lock_ch_q;
    end
`endif
  end

  assign can_load = !out_valid_q || bus.out_ready;
  assign load     = gnt_any && can_load && !reset;

  // Per-lane accept: only the granted lane, only when the register can take it.
  for (genvar i = 0; i < N; i++) begin : g_rdy
    assign bus.in_ready[i] = load && (gnt_idx == SELW'(i));
  end

  // Output register and rr pointer next state.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[gnt_idx];
      out_sel_d   = gnt_idx;
      if (bus.mode)
        ptr_d = (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and pointer; reset drops any held beat immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

`ifdef RR_ARB_MUX_LOCK_EN
  // Lock FSM next state: every load either opens or closes a lock.
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    if (load) begin
      if (bus.in_last[gnt_idx]) begin
        state_d = IDLE;
      end else begin
        state_d   = LOCKED;
        lock_ch_d = gnt_idx;
      end
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      lock_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule
